// File: rtl/rvfi_comparator.sv
// Lockstep checker for RVFI retirement streams: buffers DUT and reference packets
// in two FIFOs, pops the heads in pairs and flags the first divergence.
module rvfi_comparator #(
  parameter int XLEN    = 32,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 1000,
  parameter int PKT_W   = 102 + 5*XLEN + XLEN/8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable_i,
  input  logic             clear_i,
  input  logic             dut_valid_i,
  input  logic [PKT_W-1:0] dut_pkt_i,
  input  logic             ref_valid_i,
  input  logic [PKT_W-1:0] ref_pkt_i,
  output logic             match_o,
  output logic             mismatch_o,
  output logic [3:0]       mismatch_field_o,
  output logic [63:0]      mismatch_order_o,
  output logic             overflow_o,
  output logic             timeout_o,
  output logic [31:0]      compare_count_o,
  output logic             halted_o
);

  localparam int AW       = $clog2(DEPTH);
  localparam int TW       = $clog2(TIMEOUT + 1);
  localparam int MW       = XLEN / 8;
  localparam int MWD_LSB  = 0;
  localparam int MA_LSB   = XLEN;
  localparam int MSK_LSB  = 2 * XLEN;
  localparam int RDW_LSB  = MSK_LSB + MW;
  localparam int RDA_LSB  = RDW_LSB + XLEN;
  localparam int PCW_LSB  = RDA_LSB + 5;
  localparam int PCR_LSB  = PCW_LSB + XLEN;
  localparam int TRAP_LSB = PCR_LSB + XLEN;
  localparam int INSN_LSB = TRAP_LSB + 1;
  localparam int ORD_LSB  = INSN_LSB + 32;

  typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

  state_t           state, state_next;
  logic [PKT_W-1:0] dut_mem [DEPTH];
  logic [PKT_W-1:0] ref_mem [DEPTH];
  logic [AW:0]      dut_wr, dut_rd, ref_wr, ref_rd;
  logic [TW-1:0]    tmo_cnt;
  logic [PKT_W-1:0] dut_head, ref_head;
  logic             dut_empty, ref_empty, dut_full, ref_full;
  logic             pop, dut_push, ref_push, overflow_evt;
  logic             one_sided, timeout_evt, match_evt, mismatch_evt;
  logic             rd_live, mem_live;
  logic [9:0]       diff;
  logic [3:0]       field_idx;

  assign dut_empty = (dut_wr == dut_rd);
  assign ref_empty = (ref_wr == ref_rd);
  assign dut_full  = (dut_wr[AW] != dut_rd[AW]) && (dut_wr[AW-1:0] == dut_rd[AW-1:0]);
  assign ref_full  = (ref_wr[AW] != ref_rd[AW]) && (ref_wr[AW-1:0] == ref_rd[AW-1:0]);
  assign dut_head  = dut_mem[dut_rd[AW-1:0]];
  assign ref_head  = ref_mem[ref_rd[AW-1:0]];

  // A full FIFO may still accept a push when its head leaves on the same edge.
  assign pop          = (state == RUN) && enable_i && !dut_empty && !ref_empty;
  assign dut_push     = dut_valid_i && (!dut_full || pop);
  assign ref_push     = ref_valid_i && (!ref_full || pop);
  assign overflow_evt = (dut_valid_i && dut_full && !pop) || (ref_valid_i && ref_full && !pop);
  assign one_sided    = (state == RUN) && (dut_empty != ref_empty);
  assign timeout_evt  = one_sided && (tmo_cnt == TW'(TIMEOUT - 1));
  assign match_evt    = pop && (diff == '0);
  assign mismatch_evt = pop && (diff != '0);
  assign halted_o     = (state == HALT);

  // Write data and memory payload only matter when either side actually uses them.
  always_comb begin
    rd_live  = (dut_head[RDA_LSB +: 5] != 5'd0) || (ref_head[RDA_LSB +: 5] != 5'd0);
    mem_live = (dut_head[MSK_LSB +: MW] != '0) || (ref_head[MSK_LSB +: MW] != '0);
    diff[0]  = dut_head[ORD_LSB +: 64]   != ref_head[ORD_LSB +: 64];
    diff[1]  = dut_head[INSN_LSB +: 32]  != ref_head[INSN_LSB +: 32];
    diff[2]  = dut_head[TRAP_LSB]        != ref_head[TRAP_LSB];
    diff[3]  = dut_head[PCR_LSB +: XLEN] != ref_head[PCR_LSB +: XLEN];
    diff[4]  = dut_head[PCW_LSB +: XLEN] != ref_head[PCW_LSB +: XLEN];
    diff[5]  = dut_head[RDA_LSB +: 5]    != ref_head[RDA_LSB +: 5];
    diff[6]  = rd_live  && (dut_head[RDW_LSB +: XLEN] != ref_head[RDW_LSB +: XLEN]);
    diff[7]  = dut_head[MSK_LSB +: MW]   != ref_head[MSK_LSB +: MW];
    diff[8]  = mem_live && (dut_head[MA_LSB +: XLEN]  != ref_head[MA_LSB +: XLEN]);
    diff[9]  = mem_live && (dut_head[MWD_LSB +: XLEN] != ref_head[MWD_LSB +: XLEN]);
    field_idx = 4'd0;
    for (int i = 9; i >= 0; i--) begin
      if (diff[i]) field_idx = 4'(i);
    end
  end

  always_comb begin
    state_next = state;
    if (clear_i) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE: if (enable_i) begin
          state_next = (mismatch_o || overflow_o || timeout_o || overflow_evt) ? HALT : RUN;
        end
        RUN: begin
          if (mismatch_evt || overflow_evt || timeout_evt) state_next = HALT;
          else if (!enable_i)                              state_next = IDLE;
        end
        HALT:    state_next = HALT;
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (dut_push && !clear_i) dut_mem[dut_wr[AW-1:0]] <= dut_pkt_i;
    if (ref_push && !clear_i) ref_mem[ref_wr[AW-1:0]] <= ref_pkt_i;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dut_wr <= '0; dut_rd <= '0; ref_wr <= '0; ref_rd <= '0;
      tmo_cnt          <= '0;
      match_o          <= 1'b0;
      mismatch_o       <= 1'b0;
      mismatch_field_o <= '0;
      mismatch_order_o <= '0;
      overflow_o       <= 1'b0;
      timeout_o        <= 1'b0;
      compare_count_o  <= '0;
    end else if (clear_i) begin
      dut_wr <= '0; dut_rd <= '0; ref_wr <= '0; ref_rd <= '0;
      tmo_cnt          <= '0;
      match_o          <= 1'b0;
      mismatch_o       <= 1'b0;
      mismatch_field_o <= '0;
      mismatch_order_o <= '0;
      overflow_o       <= 1'b0;
      timeout_o        <= 1'b0;
      compare_count_o  <= '0;
    end else begin
      if (dut_push) dut_wr <= dut_wr + (AW+1)'(1);
      if (ref_push) ref_wr <= ref_wr + (AW+1)'(1);
      if (pop) begin
        dut_rd <= dut_rd + (AW+1)'(1);
        ref_rd <= ref_rd + (AW+1)'(1);
      end
      tmo_cnt <= one_sided ? tmo_cnt + TW'(1) : '0;
      match_o <= match_evt;
      if (overflow_evt) overflow_o <= 1'b1;
      if (timeout_evt)  timeout_o  <= 1'b1;
      if (mismatch_evt && !mismatch_o) begin
        mismatch_o       <= 1'b1;
        mismatch_field_o <= field_idx;
        mismatch_order_o <= dut_head[ORD_LSB +: 64];
      end
      if (match_evt && (compare_count_o != 32'hFFFF_FFFF)) compare_count_o <= compare_count_o + 32'd1;
    end
  end

endmodule

// File: tb/tb_rvfi_comparator.sv
// Randomized bench for rvfi_comparator: packets are built as field records and a
// queue-free schedule model predicts when each pair pops and how it compares.
module tb_rvfi_comparator;

  localparam int PKT_W = 266;

  typedef struct {
    logic [63:0] order;
    logic [31:0] insn;
    logic        trap;
    logic [31:0] pc_rdata;
    logic [31:0] pc_wdata;
    logic [4:0]  rd1_addr;
    logic [31:0] rd1_wdata;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
  } pkt_t;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             enable_i, clear_i, dut_valid_i, ref_valid_i;
  logic [PKT_W-1:0] dut_pkt_i, ref_pkt_i;
  logic             match_o, mismatch_o, overflow_o, timeout_o, halted_o;
  logic [3:0]       mismatch_field_o;
  logic [63:0]      mismatch_order_o;
  logic [31:0]      compare_count_o;

  int   checks = 0;
  int   errors = 0;
  int   exp_count = 0;
  pkt_t dq [8];
  pkt_t rq [8];

  rvfi_comparator #(.XLEN(32), .DEPTH(4), .TIMEOUT(10)) dut (
    .clk(clk), .reset_n(reset_n), .enable_i(enable_i), .clear_i(clear_i),
    .dut_valid_i(dut_valid_i), .dut_pkt_i(dut_pkt_i),
    .ref_valid_i(ref_valid_i), .ref_pkt_i(ref_pkt_i),
    .match_o(match_o), .mismatch_o(mismatch_o), .mismatch_field_o(mismatch_field_o),
    .mismatch_order_o(mismatch_order_o), .overflow_o(overflow_o), .timeout_o(timeout_o),
    .compare_count_o(compare_count_o), .halted_o(halted_o)
  );

  always #5 clk = ~clk;

  function automatic logic [PKT_W-1:0] pack(input pkt_t p);
    return {p.order, p.insn, p.trap, p.pc_rdata, p.pc_wdata, p.rd1_addr,
            p.rd1_wdata, p.mem_wmask, p.mem_addr, p.mem_wdata};
  endfunction

  function automatic pkt_t rand_pkt();
    pkt_t p;
    p.order     = {$urandom, $urandom};
    p.insn      = $urandom;
    p.trap      = 1'($urandom_range(0, 1));
    p.pc_rdata  = $urandom;
    p.pc_wdata  = $urandom;
    p.rd1_addr  = 5'($urandom_range(1, 31));
    p.rd1_wdata = $urandom;
    p.mem_wmask = 4'($urandom_range(1, 15));
    p.mem_addr  = $urandom;
    p.mem_wdata = $urandom;
    return p;
  endfunction

  function automatic pkt_t perturb(input pkt_t p, input int f);
    pkt_t q = p;
    case (f)
      0: q.order     ^= 64'd1 << $urandom_range(0, 63);
      1: q.insn      ^= 32'd1 << $urandom_range(0, 31);
      2: q.trap       = ~q.trap;
      3: q.pc_rdata  ^= 32'd1 << $urandom_range(0, 31);
      4: q.pc_wdata  ^= 32'd1 << $urandom_range(0, 31);
      5: q.rd1_addr  ^= 5'd1 << $urandom_range(0, 4);
      6: q.rd1_wdata ^= 32'd1 << $urandom_range(0, 31);
      7: q.mem_wmask ^= 4'd1 << $urandom_range(0, 3);
      8: q.mem_addr  ^= 32'd1 << $urandom_range(0, 31);
      default: q.mem_wdata ^= 32'd1 << $urandom_range(0, 31);
    endcase
    return q;
  endfunction

  // Lowest differing field index, or -1 when the pair counts as a match.
  function automatic int model_cmp(input pkt_t d, input pkt_t r);
    bit rd_used  = !(d.rd1_addr == 0 && r.rd1_addr == 0);
    bit mem_used = !(d.mem_wmask == 0 && r.mem_wmask == 0);
    if (d.order    != r.order)    return 0;
    if (d.insn     != r.insn)     return 1;
    if (d.trap     != r.trap)     return 2;
    if (d.pc_rdata != r.pc_rdata) return 3;
    if (d.pc_wdata != r.pc_wdata) return 4;
    if (d.rd1_addr != r.rd1_addr) return 5;
    if (rd_used  && d.rd1_wdata != r.rd1_wdata) return 6;
    if (d.mem_wmask != r.mem_wmask) return 7;
    if (mem_used && d.mem_addr  != r.mem_addr)  return 8;
    if (mem_used && d.mem_wdata != r.mem_wdata) return 9;
    return -1;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_clear();
    clear_i = 1'b1;
    step();
    clear_i = 1'b0;
    exp_count = 0;
  endtask

  task automatic start_run();
    enable_i = 1'b1;
    do_clear();
  endtask

  // Drive n pairs from dq/rq with fixed per-side offsets sd/sr and check every cycle.
  task automatic run_stream(input int n, input int sd, input int sr);
    int d_at [8];
    int r_at [8];
    int base, prev, avail, p, res, last, mm_cycle, mm_field;
    logic [63:0] mexp, mm_order;
    bit exp_mm;
    base = 0;
    for (int i = 0; i < n; i++) begin
      d_at[i] = base + sd;
      r_at[i] = base + sr;
      base += 1 + $urandom_range(0, 1);
    end
    prev = -1; mm_cycle = -1; mm_field = 0; mm_order = '0; mexp = '0;
    for (int i = 0; i < n; i++) begin
      if (mm_cycle >= 0) break;
      avail = ((d_at[i] > r_at[i]) ? d_at[i] : r_at[i]) + 1;
      p = (avail > prev + 1) ? avail : prev + 1;
      prev = p;
      res = model_cmp(dq[i], rq[i]);
      if (res < 0) begin
        mexp[p + 1] = 1'b1;
        exp_count++;
      end else begin
        mm_cycle = p + 1;
        mm_field = res;
        mm_order = dq[i].order;
      end
    end
    last = ((d_at[n-1] > r_at[n-1]) ? d_at[n-1] : r_at[n-1]) + 6;
    for (int cyc = 0; cyc <= last; cyc++) begin
      exp_mm = (mm_cycle >= 0) && (cyc >= mm_cycle);
      checks++;
      if (match_o !== mexp[cyc]) begin
        errors++;
        $display("[TB] FAIL stream_match cycle %0d: got %b expected %b", cyc, match_o, mexp[cyc]);
      end
      checks++;
      if (mismatch_o !== exp_mm || halted_o !== exp_mm) begin
        errors++;
        $display("[TB] FAIL stream_halt cycle %0d: got mismatch=%b halted=%b expected %b", cyc, mismatch_o, halted_o, exp_mm);
      end
      dut_valid_i = 1'b0;
      ref_valid_i = 1'b0;
      for (int i = 0; i < n; i++) begin
        if (d_at[i] == cyc) begin dut_valid_i = 1'b1; dut_pkt_i = pack(dq[i]); end
        if (r_at[i] == cyc) begin ref_valid_i = 1'b1; ref_pkt_i = pack(rq[i]); end
      end
      step();
    end
    dut_valid_i = 1'b0;
    ref_valid_i = 1'b0;
    checks++;
    if (compare_count_o !== 32'(exp_count)) begin
      errors++;
      $display("[TB] FAIL stream_count: got %0d expected %0d", compare_count_o, exp_count);
    end
    checks++;
    if (overflow_o !== 1'b0 || timeout_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL stream_flags: got overflow=%b timeout=%b expected 0 0", overflow_o, timeout_o);
    end
    if (mm_cycle >= 0) begin
      checks++;
      if (mismatch_field_o !== 4'(mm_field) || mismatch_order_o !== mm_order) begin
        errors++;
        $display("[TB] FAIL stream_capture: got field=%0d order=%0h expected field=%0d order=%0h",
                 mismatch_field_o, mismatch_order_o, mm_field, mm_order);
      end
    end
  endtask

  task automatic test_reset();
    pkt_t p;
    reset_n = 1'b0; enable_i = 1'b0; clear_i = 1'b0;
    dut_valid_i = 1'b0; ref_valid_i = 1'b0; dut_pkt_i = '0; ref_pkt_i = '0;
    repeat (2) step();
    checks++;
    if ({match_o, mismatch_o, overflow_o, timeout_o, halted_o, mismatch_field_o} !== '0 ||
        mismatch_order_o !== '0 || compare_count_o !== '0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got flags=%b field=%0d order=%0h count=%0d expected all 0",
               {match_o, mismatch_o, overflow_o, timeout_o, halted_o}, mismatch_field_o, mismatch_order_o, compare_count_o);
    end
    reset_n = 1'b1;
    step();
    start_run();
    dq[0] = rand_pkt(); rq[0] = dq[0];
    run_stream(1, 0, 0);
    p = rand_pkt();
    dut_valid_i = 1'b1; ref_valid_i = 1'b1; dut_pkt_i = pack(p); ref_pkt_i = pack(p);
    step();
    dut_valid_i = 1'b0; ref_valid_i = 1'b0;
    #1 reset_n = 1'b0;
    #1;
    checks++;
    if (compare_count_o !== 32'd0 || halted_o !== 1'b0 || match_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_async: got count=%0d halted=%b match=%b expected 0 0 0", compare_count_o, halted_o, match_o);
    end
    #1 reset_n = 1'b1;
    exp_count = 0;
    for (int k = 0; k < 5; k++) begin
      step();
      checks++;
      if (match_o !== 1'b0 || compare_count_o !== 32'd0) begin
        errors++;
        $display("[TB] FAIL reset_discard cycle %0d: got match=%b count=%0d expected 0 0", k, match_o, compare_count_o);
      end
    end
  endtask

  task automatic test_match_same_cycle();
    start_run();
    for (int i = 0; i < 3; i++) begin dq[i] = rand_pkt(); rq[i] = dq[i]; end
    run_stream(3, 0, 0);
  endtask

  task automatic test_skewed_ref();
    start_run();
    for (int i = 0; i < 3; i++) begin dq[i] = rand_pkt(); rq[i] = dq[i]; end
    run_stream(3, 0, 2);
  endtask

  task automatic test_ignore_fields();
    start_run();
    for (int i = 0; i < 3; i++) begin dq[i] = rand_pkt(); rq[i] = dq[i]; end
    dq[1].rd1_addr = 5'd0;  rq[1].rd1_addr = 5'd0;  rq[1].rd1_wdata = ~dq[1].rd1_wdata;
    dq[1].mem_wmask = 4'd0; rq[1].mem_wmask = 4'd0;
    rq[1].mem_addr = ~dq[1].mem_addr; rq[1].mem_wdata = dq[1].mem_wdata ^ 32'h55;
    run_stream(3, 0, 0);
  endtask

  task automatic test_mismatch_rd1();
    start_run();
    for (int i = 0; i < 4; i++) begin dq[i] = rand_pkt(); rq[i] = dq[i]; end
    dq[1].order = 64'd7; rq[1].order = 64'd7;
    dq[1].rd1_addr = 5'd5; rq[1].rd1_addr = 5'd5;
    rq[1].rd1_wdata = dq[1].rd1_wdata ^ 32'h0000_0100;
    run_stream(4, 0, 0);
    checks++;
    if (mismatch_field_o !== 4'd6 || mismatch_order_o !== 64'd7 || compare_count_o !== 32'd1) begin
      errors++;
      $display("[TB] FAIL mismatch_rd1: got field=%0d order=%0d count=%0d expected 6 7 1",
               mismatch_field_o, mismatch_order_o, compare_count_o);
    end
  endtask

  task automatic test_random_mismatch();
    int k, sk;
    for (int it = 0; it < 5; it++) begin
      start_run();
      for (int i = 0; i < 4; i++) begin dq[i] = rand_pkt(); rq[i] = dq[i]; end
      k = $urandom_range(0, 3);
      rq[k] = perturb(rq[k], $urandom_range(0, 9));
      if ($urandom_range(0, 1) == 1) rq[k] = perturb(rq[k], $urandom_range(0, 9));
      sk = $urandom_range(0, 2);
      if ($urandom_range(0, 1) == 1) run_stream(4, sk, 0);
      else                           run_stream(4, 0, sk);
    end
  endtask

  task automatic test_random_stream();
    int sk;
    for (int it = 0; it < 3; it++) begin
      start_run();
      for (int i = 0; i < 8; i++) begin dq[i] = rand_pkt(); rq[i] = dq[i]; end
      sk = $urandom_range(0, 2);
      if (it == 1) run_stream(8, sk, 0);
      else         run_stream(8, 0, sk);
    end
  endtask

  // Fill both FIFOs while idle, then keep pushing into full FIFOs as heads drain.
  task automatic test_back_to_back();
    pkt_t p;
    int pulses;
    enable_i = 1'b0;
    do_clear();
    for (int c = 0; c < 4; c++) begin
      p = rand_pkt();
      dut_valid_i = 1'b1; ref_valid_i = 1'b1; dut_pkt_i = pack(p); ref_pkt_i = pack(p);
      step();
    end
    dut_valid_i = 1'b0; ref_valid_i = 1'b0;
    enable_i = 1'b1;
    step();
    pulses = 0;
    for (int j = 1; j <= 10; j++) begin
      checks++;
      if (match_o !== ((j >= 2) && (j <= 9))) begin
        errors++;
        $display("[TB] FAIL b2b_match cycle %0d: got %b expected %b", j, match_o, (j >= 2) && (j <= 9));
      end
      if (match_o === 1'b1) pulses++;
      dut_valid_i = 1'b0; ref_valid_i = 1'b0;
      if (j <= 4) begin
        p = rand_pkt();
        dut_valid_i = 1'b1; ref_valid_i = 1'b1; dut_pkt_i = pack(p); ref_pkt_i = pack(p);
      end
      step();
    end
    dut_valid_i = 1'b0; ref_valid_i = 1'b0;
    checks++;
    if (pulses != 8 || compare_count_o !== 32'd8 || overflow_o !== 1'b0 || halted_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL b2b_totals: got pulses=%0d count=%0d overflow=%b halted=%b expected 8 8 0 0",
               pulses, compare_count_o, overflow_o, halted_o);
    end
  endtask

  task automatic test_overflow();
    pkt_t p;
    enable_i = 1'b0;
    do_clear();
    for (int c = 0; c < 5; c++) begin
      p = rand_pkt();
      dut_valid_i = 1'b1; dut_pkt_i = pack(p);
      ref_valid_i = (c < 4); ref_pkt_i = pack(p);
      step();
      checks++;
      if (overflow_o !== (c == 4) || halted_o !== 1'b0) begin
        errors++;
        $display("[TB] FAIL overflow_push %0d: got overflow=%b halted=%b expected %b 0", c, overflow_o, halted_o, c == 4);
      end
    end
    dut_valid_i = 1'b0; ref_valid_i = 1'b0;
    enable_i = 1'b1;
    step();
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (halted_o !== 1'b1 || match_o !== 1'b0 || compare_count_o !== 32'd0) begin
        errors++;
        $display("[TB] FAIL overflow_halt %0d: got halted=%b match=%b count=%0d expected 1 0 0", k, halted_o, match_o, compare_count_o);
      end
      step();
    end
    enable_i = 1'b0;
    do_clear();
    checks++;
    if ({mismatch_o, overflow_o, timeout_o, halted_o, match_o} !== 5'b0 || compare_count_o !== 32'd0) begin
      errors++;
      $display("[TB] FAIL overflow_clear: got flags=%b count=%0d expected 0 0",
               {mismatch_o, overflow_o, timeout_o, halted_o, match_o}, compare_count_o);
    end
    p = rand_pkt();
    enable_i = 1'b1;
    dut_valid_i = 1'b1; ref_valid_i = 1'b1; dut_pkt_i = pack(p); ref_pkt_i = pack(p);
    step();
    dut_valid_i = 1'b0; ref_valid_i = 1'b0;
    checks++;
    if (match_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL clear_first_cycle: got %b expected 0", match_o);
    end
    step();
    checks++;
    if (match_o !== 1'b1) begin
      errors++;
      $display("[TB] FAIL clear_match: got %b expected 1", match_o);
    end
    repeat (4) step();
    checks++;
    if (compare_count_o !== 32'd1) begin
      errors++;
      $display("[TB] FAIL clear_flushed: got count=%0d expected 1", compare_count_o);
    end
  endtask

  task automatic test_timeout();
    start_run();
    dut_valid_i = 1'b1; dut_pkt_i = pack(rand_pkt());
    step();
    dut_valid_i = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      checks++;
      if (timeout_o !== 1'b0 || halted_o !== 1'b0) begin
        errors++;
        $display("[TB] FAIL timeout_early %0d: got timeout=%b halted=%b expected 0 0", k, timeout_o, halted_o);
      end
      step();
    end
    checks++;
    if (timeout_o !== 1'b1 || halted_o !== 1'b1) begin
      errors++;
      $display("[TB] FAIL timeout_fire: got timeout=%b halted=%b expected 1 1", timeout_o, halted_o);
    end
  endtask

  initial begin
    test_reset();
    test_match_same_cycle();
    test_skewed_ref();
    test_ignore_fields();
    test_mismatch_rd1();
    test_random_mismatch();
    test_random_stream();
    test_back_to_back();
    test_overflow();
    test_timeout();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
